gmii_frame_tx: RTL and testbench



---
 rtl/gmii_frame_tx.sv | 185 ++++++++++++++++++
 tb/tb_gmii_frame_tx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_frame_tx.sv
// gmii_frame_tx -- GMII transmit framer.
//
// Takes a byte stream (destination MAC first) and sends it as a complete
// Ethernet frame. Each frame gets a preamble and SFD in front. Frames shorter
// than MINLEN are padded with zeros. A CRC-32 FCS is appended, and the
// inter-frame gap is enforced before the next frame may start.
//
// Ports:
//   clk, rst      GMII tx clock; asynchronous active-high reset
//   s_data[7:0]   payload byte
//   s_valid       s_data valid
//   s_last        final payload byte of the frame
//   s_ready       byte accepted when s_valid & s_ready
//   txd[7:0]      GMII transmit data (registered)
//   tx_en, tx_er  GMII enable / error (registered)
//   busy          high from frame start until the gap ends (registered)
//
// Handshake: a beat transfers on a rising edge where s_valid and s_ready are
// both high. s_ready is a function of state only and never looks at s_valid.
// Once the SFD is on the wire, the source must present a byte every cycle
// until s_last. A missing beat is an underrun: the frame is poisoned with
// tx_er, and the remainder of the stream is drained without being sent.
//
// Output timing: every output register is loaded with the value for the
// next cycle. That value is decided from the current state and inputs. A
// byte accepted in one cycle is therefore on txd in the following cycle.

module gmii_frame_tx #(
  parameter int IFG    = 12,
  parameter int MINLEN = 60,
  parameter int NPRE   = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] txd,
  output logic       tx_en,
  output logic       tx_er,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_DROP, S_GAP
  } state_t;

  localparam logic [15:0] PRE_LAST = 16'(NPRE - 1);
  localparam logic [15:0] GAP_LAST = 16'(IFG - 1);
  localparam logic [16:0] MIN17    = 17'(MINLEN);

  state_t      state, state_nx;
  logic [15:0] cnt, cnt_nx;   // payload+pad bytes sent, saturating
  logic [31:0] crc, crc_nx;   // running reflected CRC-32
  logic [15:0] tmr, tmr_nx;   // shared cycle index for PRE, FCS and GAP
  logic [7:0]  txd_nx;
  logic        tx_en_nx, tx_er_nx;
  logic [31:0] fcs;
  logic [16:0] cnt_inc;

  // Reflected CRC-32 (poly 0xEDB88320), one byte, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  assign fcs     = ~crc;
  assign cnt_inc = {1'b0, cnt} + 17'd1;
  assign s_ready = (state == S_SFD) || (state == S_DATA) || (state == S_DROP);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    crc_nx   = crc;
    tmr_nx   = tmr;
    txd_nx   = 8'h00;
    tx_en_nx = 1'b0;
    tx_er_nx = 1'b0;
    case (state)
      S_IDLE: begin
        if (s_valid) begin
          state_nx = S_PRE;
          tmr_nx   = '0;
          txd_nx   = 8'h55;
          tx_en_nx = 1'b1;
        end
      end
      S_PRE: begin
        tx_en_nx = 1'b1;
        if (tmr == PRE_LAST) begin
          // SFD goes out next; start the CRC and count fresh for the payload.
          txd_nx   = 8'hD5;
          state_nx = S_SFD;
          crc_nx   = 32'hFFFFFFFF;
          cnt_nx   = '0;
        end else begin
          txd_nx = 8'h55;
          tmr_nx = tmr + 16'd1;
        end
      end
      S_SFD, S_DATA: begin
        tx_en_nx = 1'b1;
        if (s_valid) begin
          txd_nx = s_data;
          crc_nx = crc_byte(crc, s_data);
          cnt_nx = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
          if (s_last) begin
            tmr_nx   = '0;
            state_nx = (cnt_inc < MIN17) ? S_PAD : S_FCS;
          end else begin
            state_nx = S_DATA;
          end
        end else begin
          // Underrun: one errored cycle, then drain the source quietly.
          tx_er_nx = 1'b1;
          state_nx = S_DROP;
        end
      end
      S_PAD: begin
        tx_en_nx = 1'b1;
        crc_nx   = crc_byte(crc, 8'h00);
        cnt_nx   = cnt + 16'd1;
        if (cnt_inc >= MIN17) begin
          state_nx = S_FCS;
          tmr_nx   = '0;
        end
      end
      S_FCS: begin
        tx_en_nx = 1'b1;
        case (tmr[1:0])
          2'd0:    txd_nx = fcs[7:0];
          2'd1:    txd_nx = fcs[15:8];
          2'd2:    txd_nx = fcs[23:16];
          default: txd_nx = fcs[31:24];
        endcase
        if (tmr[1:0] == 2'd3) begin
          state_nx = S_GAP;
          tmr_nx   = '0;
        end else begin
          tmr_nx = tmr + 16'd1;
        end
      end
      S_DROP: begin
        if (s_valid && s_last) begin
          state_nx = S_GAP;
          tmr_nx   = '0;
        end
      end
      S_GAP: begin
        if (tmr == GAP_LAST) state_nx = S_IDLE;
        else                 tmr_nx   = tmr + 16'd1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      crc   <= 32'hFFFFFFFF;
      tmr   <= '0;
      txd   <= 8'h00;
      tx_en <= 1'b0;
      tx_er <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      crc   <= crc_nx;
      tmr   <= tmr_nx;
      txd   <= txd_nx;
      tx_en <= tx_en_nx;
      tx_er <= tx_er_nx;
      busy  <= (state_nx != S_IDLE);
    end
  end

endmodule

// File: tb/tb_gmii_frame_tx.sv
// tb_gmii_frame_tx -- bench for gmii_frame_tx.
// Frame table plus hand sequences for back-to-back gap, underrun and
// reset during FCS. Expected wire bytes and tx_en run lengths are queued
// as stimulus is driven and consumed by a monitor on the falling edge.

module tb_gmii_frame_tx;

  localparam int IFG    = 12;
  localparam int MINLEN = 60;
  localparam int NPRE   = 7;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] s_data;
  logic       s_valid, s_last;
  logic       s_ready;
  logic [7:0] txd;
  logic       tx_en, tx_er, busy;

  gmii_frame_tx #(.IFG(IFG), .MINLEN(MINLEN), .NPRE(NPRE)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .txd(txd), .tx_en(tx_en), .tx_er(tx_er), .busy(busy)
  );

  int vectors = 0;
  int miscompares = 0;

  // scoreboard: {tx_er, txd} per tx_en-high cycle, and tx_en run lengths
  logic [8:0] exp_q[$];
  int         exp_len_q[$];

  int   en_run = 0, low_run = 0, busy_low = 0;
  int   last_gap = -1, last_busy_low = -1;
  logic prev_en = 1'b0;

  logic [31:0] crc_tab[256];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endfunction

  // table-driven reference CRC
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    return crc_tab[c[7:0] ^ d] ^ {8'h00, c[31:8]};
  endfunction

  // monitor
  always @(negedge clk) begin
    if (rst) begin
      en_run = 0; low_run = 0; busy_low = 0; prev_en = 1'b0;
    end else begin
      if (tx_en) begin
        if (!prev_en) begin
          last_gap      = low_run;
          last_busy_low = busy_low;
        end
        en_run++;
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL wire_byte: got txd=%02h tx_er=%0b, want no frame byte (t=%0t)", txd, tx_er, $time);
        end else begin
          check("wire_byte", {23'd0, tx_er, txd}, {23'd0, exp_q.pop_front()});
        end
      end else begin
        check("idle_lines", {23'd0, tx_er, txd}, 32'd0);
        if (prev_en) begin
          if (exp_len_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL en_len: got run of %0d, want no frame", en_run);
          end else begin
            check("en_len", 32'(en_run), 32'(exp_len_q.pop_front()));
          end
          check("busy_at_fall", {31'd0, busy}, 32'd1);
          en_run = 0; low_run = 0; busy_low = 0;
        end
        low_run++;
      end
      if (!busy) busy_low++;
      prev_en = tx_en;
    end
  end

  // driver: one frame; under_at > 0 drops s_valid after that many bytes
  task automatic send_frame(input int n, input int under_at, input bit hold,
                            input int exp_en, input bit udp);
    logic [7:0]  pay[];
    logic [7:0]  hdr[16];
    logic [31:0] c;
    int          i, guard;
    bit          dropping;
    pay = new[n];
    for (int k = 0; k < n; k++) pay[k] = 8'($urandom_range(0, 255));
    if (udp) begin
      hdr = '{8'h51, 8'h55, 8'h42, 8'h49, 8'h43, 8'h01, 8'hc4, 8'h6e,
              8'h1f, 8'h01, 8'hd9, 8'h0d, 8'h08, 8'h00, 8'h45, 8'h00};
      for (int k = 0; k < 16 && k < n; k++) pay[k] = hdr[k];
      for (int k = n - 4; k < n; k++) if (k >= 16) pay[k] = 8'h00;
    end
    exp_len_q.push_back(exp_en);
    for (int k = 0; k < NPRE; k++) exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'hD5});
    c = 32'hFFFFFFFF;
    i = 0; guard = 0; dropping = 1'b0;
    s_valid = 1'b1; s_data = pay[0]; s_last = (n == 1);
    while (i < n) begin
      @(negedge clk);
      if (s_ready) begin
        if (!dropping) begin
          exp_q.push_back({1'b0, pay[i]});
          c = crc_upd(c, pay[i]);
        end
        i++;
        @(posedge clk); #1;
        if (i == under_at && !dropping) begin
          s_valid = 1'b0; s_last = 1'b0;
          @(negedge clk);
          exp_q.push_back({1'b1, 8'h00});
          dropping = 1'b1;
          @(posedge clk); #1;
        end
        if (i < n) begin
          s_valid = 1'b1; s_data = pay[i]; s_last = (i == n - 1);
        end
      end else begin
        @(posedge clk); #1;
      end
      guard++;
      if (guard > 5000) begin
        fail_now("accept_timeout");
        s_valid = 1'b0; s_last = 1'b0;
        return;
      end
    end
    if (!dropping) begin
      for (int k = n; k < MINLEN; k++) begin
        exp_q.push_back({1'b0, 8'h00});
        c = crc_upd(c, 8'h00);
      end
      c = ~c;
      exp_q.push_back({1'b0, c[7:0]});
      exp_q.push_back({1'b0, c[15:8]});
      exp_q.push_back({1'b0, c[23:16]});
      exp_q.push_back({1'b0, c[31:24]});
    end
    if (!hold) begin
      s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((busy || tx_en || exp_q.size() != 0) && guard < 3000);
    if (guard >= 3000) fail_now("wait_idle");
  endtask

  typedef struct {
    int len;
    int under_at;
    bit udp;
    int exp_en;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [31:0] r;
    for (int i = 0; i < 256; i++) begin
      r = 32'(i);
      for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      crc_tab[i] = r;
    end

    //            len  under udp  tx_en cycles
    tbl[0] = '{  60,  -1, 1'b1,   72};
    tbl[1] = '{  14,  -1, 1'b0,   72};
    tbl[2] = '{   1,  -1, 1'b0,   72};
    tbl[3] = '{  59,  -1, 1'b0,   72};
    tbl[4] = '{  61,  -1, 1'b0,   73};
    tbl[5] = '{  40,  20, 1'b0,   29};
    tbl[6] = '{1500,  -1, 1'b0, 1512};
    tbl[7] = '{  64,  -1, 1'b0,   76};

    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd",     {24'd0, txd},     32'd0);
    check("rst_tx_en",   {31'd0, tx_en},   32'd0);
    check("rst_tx_er",   {31'd0, tx_er},   32'd0);
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check("rst_busy",    {31'd0, busy},    32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int v = 0; v < 8; v++) begin
      send_frame(tbl[v].len, tbl[v].under_at, 1'b0, tbl[v].exp_en, tbl[v].udp);
      wait_idle();
      @(posedge clk); #1;
    end

    // back-to-back frames with s_valid held high
    send_frame(64, -1, 1'b1, 76, 1'b0);
    send_frame(64, -1, 1'b0, 76, 1'b0);
    check("b2b_gap",      32'(last_gap),      32'(IFG));
    check("b2b_busy_low", 32'(last_busy_low), 32'd1);
    wait_idle();

    // reset pulsed while the FCS is going out
    @(posedge clk); #1;
    send_frame(64, -1, 1'b0, 76, 1'b0);
    @(posedge clk); #2;
    check("pre_rst_tx_en", {31'd0, tx_en}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_txd",   {24'd0, txd},     32'd0);
    check("async_tx_en", {31'd0, tx_en},   32'd0);
    check("async_tx_er", {31'd0, tx_er},   32'd0);
    check("async_busy",  {31'd0, busy},    32'd0);
    check("async_ready", {31'd0, s_ready}, 32'd0);
    exp_q.delete();
    exp_len_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    send_frame(30, -1, 1'b0, 72, 1'b0);
    wait_idle();

    repeat (4) @(posedge clk);
    check("exp_q_drained",   32'(exp_q.size()),     32'd0);
    check("exp_len_drained", 32'(exp_len_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    vectors++;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

endmodule
